// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared widths and FSM encoding for the instruction fetch stage
package instr_fetch_pkg;

  localparam int unsigned IF_ADDR_W = 16;
  localparam int unsigned IF_DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } if_state_e;

endpackage

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - single-outstanding instruction fetch with one-entry instruction register
// Issues one memory read per instruction from pc_in, holds the word for decode, pulses pc_adv on capture.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int ADDR_W = IF_ADDR_W,
  parameter int DATA_W = IF_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic [ADDR_W-1:0] i_pc_in,
  input  logic              i_flush,
  output logic              o_pc_adv,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_gnt,
  input  logic              i_mem_rvalid,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_ir_valid,
  output logic [DATA_W-1:0] o_ir_data,
  output logic [ADDR_W-1:0] o_ir_pc,
  input  logic              i_ir_ready
);

  if_state_e         r_state;
  logic              r_mem_req;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_ir_valid;
  logic [DATA_W-1:0] r_ir_data;
  logic [ADDR_W-1:0] r_ir_pc;
  logic              r_pc_adv;
  logic              r_drop;

  if_state_e         w_state_nxt;
  logic              w_mem_req_nxt;
  logic [ADDR_W-1:0] w_mem_addr_nxt;
  logic              w_ir_valid_nxt;
  logic [DATA_W-1:0] w_ir_data_nxt;
  logic [ADDR_W-1:0] w_ir_pc_nxt;
  logic              w_pc_adv_nxt;
  logic              w_drop_nxt;

  always_comb begin
    w_state_nxt    = r_state;
    w_mem_req_nxt  = r_mem_req;
    w_mem_addr_nxt = r_mem_addr;
    w_ir_valid_nxt = r_ir_valid;
    w_ir_data_nxt  = r_ir_data;
    w_ir_pc_nxt    = r_ir_pc;
    w_pc_adv_nxt   = 1'b0;
    w_drop_nxt     = r_drop;

    case (r_state)
      ST_IDLE: begin
        if (i_en) begin
          w_state_nxt    = ST_REQ;
          w_mem_req_nxt  = 1'b1;
          w_mem_addr_nxt = i_pc_in;
        end
      end

      ST_REQ: begin
        if (i_flush) begin
          w_mem_addr_nxt = i_pc_in;
        end else if (i_mem_gnt) begin
          w_state_nxt   = ST_WAIT;
          w_mem_req_nxt = 1'b0;
          w_drop_nxt    = 1'b0;
        end
      end

      // A flush here cannot cancel the granted read, so its data is swallowed on arrival.
      ST_WAIT: begin
        if (i_mem_rvalid) begin
          if (i_flush || r_drop) begin
            w_state_nxt    = ST_REQ;
            w_mem_req_nxt  = 1'b1;
            w_mem_addr_nxt = i_pc_in;
            w_drop_nxt     = 1'b0;
          end else begin
            w_state_nxt    = ST_HOLD;
            w_ir_valid_nxt = 1'b1;
            w_ir_data_nxt  = i_mem_rdata;
            w_ir_pc_nxt    = r_mem_addr;
            w_pc_adv_nxt   = 1'b1;
          end
        end else if (i_flush) begin
          w_drop_nxt = 1'b1;
        end
      end

      ST_HOLD: begin
        if (i_flush || i_ir_ready) begin
          w_ir_valid_nxt = 1'b0;
          if (i_en) begin
            w_state_nxt    = ST_REQ;
            w_mem_req_nxt  = 1'b1;
            w_mem_addr_nxt = i_pc_in;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_ir_valid <= 1'b0;
      r_ir_data  <= '0;
      r_ir_pc    <= '0;
      r_pc_adv   <= 1'b0;
      r_drop     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_mem_req  <= w_mem_req_nxt;
      r_mem_addr <= w_mem_addr_nxt;
      r_ir_valid <= w_ir_valid_nxt;
      r_ir_data  <= w_ir_data_nxt;
      r_ir_pc    <= w_ir_pc_nxt;
      r_pc_adv   <= w_pc_adv_nxt;
      r_drop     <= w_drop_nxt;
    end
  end

  assign o_pc_adv   = r_pc_adv;
  assign o_mem_req  = r_mem_req;
  assign o_mem_addr = r_mem_addr;
  assign o_ir_valid = r_ir_valid;
  assign o_ir_data  = r_ir_data;
  assign o_ir_pc    = r_ir_pc;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed and randomized self-checking bench for instr_fetch
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] pc_in = '0;
  logic        flush = 1'b0;
  logic        gnt = 1'b0;
  logic        rvalid = 1'b0;
  logic [15:0] rdata = '0;
  logic        ready = 1'b0;

  logic        pc_adv;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        ir_valid;
  logic [15:0] ir_data;
  logic [15:0] ir_pc;

  int n_checks = 0;
  int n_errors = 0;

  instr_fetch #(.ADDR_W(16), .DATA_W(16)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_en         (en),
    .i_pc_in      (pc_in),
    .i_flush      (flush),
    .o_pc_adv     (pc_adv),
    .o_mem_req    (mem_req),
    .o_mem_addr   (mem_addr),
    .i_mem_gnt    (gnt),
    .i_mem_rvalid (rvalid),
    .i_mem_rdata  (rdata),
    .o_ir_valid   (ir_valid),
    .o_ir_data    (ir_data),
    .o_ir_pc      (ir_pc),
    .i_ir_ready   (ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic exp_outs(input string tag, input logic e_req, input logic [15:0] e_addr,
                          input logic e_irv, input logic [15:0] e_ird, input logic [15:0] e_irpc,
                          input logic e_adv);
    check({tag, ".req"}, 16'(mem_req), 16'(e_req));
    if (e_req) check({tag, ".addr"}, mem_addr, e_addr);
    check({tag, ".irv"}, 16'(ir_valid), 16'(e_irv));
    if (e_irv) begin
      check({tag, ".ird"}, ir_data, e_ird);
      check({tag, ".irpc"}, ir_pc, e_irpc);
    end
    check({tag, ".adv"}, 16'(pc_adv), 16'(e_adv));
  endtask

  task automatic exp_reset(input string tag);
    check({tag, ".req"}, 16'(mem_req), 16'h0);
    check({tag, ".addr"}, mem_addr, 16'h0);
    check({tag, ".irv"}, 16'(ir_valid), 16'h0);
    check({tag, ".ird"}, ir_data, 16'h0);
    check({tag, ".irpc"}, ir_pc, 16'h0);
    check({tag, ".adv"}, 16'(pc_adv), 16'h0);
  endtask

  function automatic logic [15:0] memf(input logic [15:0] a);
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  // Memory-side view for the random phase: one granted read in flight, possibly doomed by a flush.
  logic        m_out, m_doom;
  logic [15:0] m_addr;
  logic        p_en, p_flush, p_gnt, p_rvalid, p_ready, p_req, p_irv;
  logic [15:0] p_pc, p_addr, p_ird, p_irpc;
  logic        cap, exp_irv, e_req;
  logic [15:0] e_addr;
  int          n_cap = 0;

  initial begin
    cyc();
    exp_reset("t1.reset");

    rst_n = 1'b1; en = 1'b1; pc_in = 16'h0006;
    cyc(); exp_outs("t1.req", 1'b1, 16'h0006, 1'b0, '0, '0, 1'b0);
    gnt = 1'b1;
    cyc(); exp_outs("t1.wait", 1'b0, '0, 1'b0, '0, '0, 1'b0);
    gnt = 1'b0; rvalid = 1'b1; rdata = 16'hA5A5;
    cyc(); exp_outs("t1.cap", 1'b0, '0, 1'b1, 16'hA5A5, 16'h0006, 1'b1);
    rvalid = 1'b0; en = 1'b0;
    cyc(); exp_outs("t1.hold", 1'b0, '0, 1'b1, 16'hA5A5, 16'h0006, 1'b0);
    ready = 1'b1;
    cyc(); exp_outs("t1.idle", 1'b0, '0, 1'b0, '0, '0, 1'b0);
    ready = 1'b0;

    en = 1'b1; pc_in = 16'h1234;
    cyc(); exp_outs("t2.req", 1'b1, 16'h1234, 1'b0, '0, '0, 1'b0);
    pc_in = 16'h9999;
    for (int i = 0; i < 3; i++) begin
      cyc(); exp_outs("t2.stall", 1'b1, 16'h1234, 1'b0, '0, '0, 1'b0);
    end
    gnt = 1'b1;
    cyc(); exp_outs("t2.gnt", 1'b0, '0, 1'b0, '0, '0, 1'b0);
    gnt = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc(); exp_outs("t2.wait", 1'b0, '0, 1'b0, '0, '0, 1'b0);
    end
    rvalid = 1'b1; rdata = 16'hBEEF;
    cyc(); exp_outs("t2.cap", 1'b0, '0, 1'b1, 16'hBEEF, 16'h1234, 1'b1);
    rvalid = 1'b0; pc_in = 16'h2222;

    for (int i = 0; i < 4; i++) begin
      cyc(); exp_outs("t3.hold", 1'b0, '0, 1'b1, 16'hBEEF, 16'h1234, 1'b0);
    end
    ready = 1'b1;
    cyc(); exp_outs("t3.next", 1'b1, 16'h2222, 1'b0, '0, '0, 1'b0);
    ready = 1'b0;

    gnt = 1'b1;
    cyc(); exp_outs("t4.gnt", 1'b0, '0, 1'b0, '0, '0, 1'b0);
    gnt = 1'b0; flush = 1'b1; pc_in = 16'h0008;
    cyc(); exp_outs("t4.flush", 1'b0, '0, 1'b0, '0, '0, 1'b0);
    flush = 1'b0; rvalid = 1'b1; rdata = 16'h7777;
    cyc(); exp_outs("t4.drop", 1'b1, 16'h0008, 1'b0, '0, '0, 1'b0);
    rvalid = 1'b0;

    gnt = 1'b1;
    cyc(); exp_outs("t5.gnt", 1'b0, '0, 1'b0, '0, '0, 1'b0);
    gnt = 1'b0; rvalid = 1'b1; rdata = 16'h1111;
    cyc(); exp_outs("t5.cap", 1'b0, '0, 1'b1, 16'h1111, 16'h0008, 1'b1);
    rvalid = 1'b0; flush = 1'b1; ready = 1'b1; pc_in = 16'h0010;
    cyc(); exp_outs("t5.holdflush", 1'b1, 16'h0010, 1'b0, '0, '0, 1'b0);
    flush = 1'b0; ready = 1'b0; gnt = 1'b1;
    cyc(); exp_outs("t5.gnt2", 1'b0, '0, 1'b0, '0, '0, 1'b0);
    gnt = 1'b0; flush = 1'b1; rvalid = 1'b1; rdata = 16'h2222; pc_in = 16'h0020;
    cyc(); exp_outs("t5.flushrv", 1'b1, 16'h0020, 1'b0, '0, '0, 1'b0);
    rvalid = 1'b0; pc_in = 16'h0030;
    cyc(); exp_outs("t5.reqflush", 1'b1, 16'h0030, 1'b0, '0, '0, 1'b0);
    flush = 1'b0;

    gnt = 1'b1;
    cyc(); exp_outs("t6.gnt", 1'b0, '0, 1'b0, '0, '0, 1'b0);
    gnt = 1'b0; rst_n = 1'b0;
    #1 exp_reset("t6.async");
    cyc();
    rst_n = 1'b1; en = 1'b0; rvalid = 1'b1; rdata = 16'hDEAD;
    cyc(); exp_reset("t6.late");
    rvalid = 1'b0;
    cyc(); exp_reset("t6.idle");

    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    m_out = 1'b0; m_doom = 1'b0; m_addr = '0;
    for (int c = 0; c < 3000; c++) begin
      en    = ($urandom_range(0, 9) != 0);
      pc_in = 16'($urandom);
      ready = ($urandom_range(0, 1) == 1);
      gnt   = mem_req && ($urandom_range(0, 9) < 4);
      flush = !gnt && ($urandom_range(0, 99) < 8);
      if (m_out) begin
        rvalid = ($urandom_range(0, 9) < 4);
        rdata  = memf(m_addr);
      end else begin
        rvalid = ($urandom_range(0, 9) == 0);
        rdata  = 16'($urandom);
      end
      p_en = en; p_pc = pc_in; p_flush = flush; p_gnt = gnt; p_rvalid = rvalid; p_ready = ready;
      p_req = mem_req; p_addr = mem_addr; p_irv = ir_valid; p_ird = ir_data; p_irpc = ir_pc;
      cyc();

      cap     = p_rvalid && m_out && !m_doom && !p_flush;
      exp_irv = cap || (p_irv && !p_ready && !p_flush);
      check("rnd.adv", 16'(pc_adv), 16'(cap));
      check("rnd.irv", 16'(ir_valid), 16'(exp_irv));
      if (cap) begin
        check("rnd.ird", ir_data, memf(m_addr));
        check("rnd.irpc", ir_pc, m_addr);
        n_cap++;
      end else if (exp_irv) begin
        check("rnd.ird_hold", ir_data, p_ird);
        check("rnd.irpc_hold", ir_pc, p_irpc);
      end

      if (p_req) begin
        e_req  = !p_gnt || p_flush;
        e_addr = p_flush ? p_pc : p_addr;
      end else if (m_out) begin
        e_req  = p_rvalid && !cap;
        e_addr = p_pc;
      end else if (p_irv) begin
        e_req  = (p_ready || p_flush) && p_en;
        e_addr = p_pc;
      end else begin
        e_req  = p_en;
        e_addr = p_pc;
      end
      check("rnd.req", 16'(mem_req), 16'(e_req));
      if (e_req) check("rnd.addr", mem_addr, e_addr);

      if (p_req && p_gnt && !p_flush) begin
        m_out  = 1'b1;
        m_addr = p_addr;
        m_doom = 1'b0;
      end else if (m_out) begin
        if (p_flush) m_doom = 1'b1;
        if (p_rvalid) m_out = 1'b0;
      end
    end
    check("rnd.live", 16'(n_cap > 100), 16'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
